// File: rtl/drm_fifo_pkg.sv
// drm_fifo_pkg
// Shared constants and types for the DRM-backed FWFT FIFO controller and the
// drm_32x1024 RAM model it drives.
//   DRM_DATA_WIDTH   default stream / RAM word width
//   DRM_ADDR_WIDTH   default RAM address width
//   DRM_DEPTH        default RAM depth (2**DRM_ADDR_WIDTH)
//   DRM_AFULL_THRESH default almost-full level
//   BUF_CNT_WIDTH    width of the output prefetch buffer occupancy
//   ptr_t            RAM address / pointer type at the default width
//   buf_cnt_t        output buffer occupancy type
package drm_fifo_pkg;

    localparam int unsigned DRM_DATA_WIDTH   = 32;
    localparam int unsigned DRM_ADDR_WIDTH   = 10;
    localparam int unsigned DRM_DEPTH        = 2 ** DRM_ADDR_WIDTH;
    localparam int unsigned DRM_AFULL_THRESH = 1008;

    // Prefetch buffer holds at most 2 words, so occupancy needs 2 bits.
    localparam int unsigned BUF_CNT_WIDTH = 2;
    localparam int unsigned BUF_ENTRIES   = 2;

    typedef logic [DRM_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [BUF_CNT_WIDTH-1:0]  buf_cnt_t;

endpackage

// File: rtl/drm_32x1024.sv
// drm_32x1024
// Behavioural model of the 32x1024 simple dual-port DRM block: one synchronous
// write port and one read port with a registered (1-cycle latency) output.
// Contents are never cleared by reset; only the read output register is.
//   wr_clk, wr_rst   write port clock and active-high reset
//   wr_en, wr_addr, wr_data  write strobe, address and data
//   rd_clk, rd_rst   read port clock and active-high asynchronous reset
//   rd_addr          read address, sampled on rd_clk
//   rd_data          read data, valid the cycle after rd_addr is sampled
module drm_32x1024
    import drm_fifo_pkg::*;
(
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic                      wr_en,
    input  ptr_t                      wr_addr,
    input  logic [DRM_DATA_WIDTH-1:0] wr_data,
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  ptr_t                      rd_addr,
    output logic [DRM_DATA_WIDTH-1:0] rd_data
);

    logic [DRM_DATA_WIDTH-1:0] mem [DRM_DEPTH];

    // Writes are blocked while the write port is held in reset.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !wr_rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/drm_fifo_obuf.sv
// drm_fifo_obuf
// Two-entry ordered capture/output buffer that absorbs the RAM read latency.
// Words arrive on in_valid/in_data (no back-pressure: the issuing logic never
// launches a read unless a slot is guaranteed) and leave on a valid/ready port.
// Implemented as a head register (always the oldest word) plus a tail register.
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       capture strobe (RAM data returning this cycle)
//   in_data        word to capture
//   out_valid      buffer holds at least one word
//   out_ready      downstream accepts the head word
//   out_data       head word, held stable while out_valid & ~out_ready
//   occupancy      current number of words held (0..2)
module drm_fifo_obuf
    import drm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DRM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output buf_cnt_t              occupancy
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    buf_cnt_t              occ_q, occ_d;
    logic                  pop;

    assign out_valid = (occ_q != '0);
    assign out_data  = head_q;
    assign occupancy = occ_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (in_valid) begin
                    head_d = in_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({pop, in_valid})
                    2'b11:   head_d = in_data;
                    2'b10:   occ_d  = 2'd0;
                    2'b01: begin
                        tail_d = in_data;
                        occ_d  = 2'd2;
                    end
                    default: ;
                endcase
            end
            2'd2: begin
                // A capture without a pop cannot happen when full: the issue
                // check guarantees a free slot for every in-flight read.
                if (pop) begin
                    head_d = tail_q;
                    if (in_valid) begin
                        tail_d = in_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/drm_fifo_ctrl.sv
// drm_fifo_ctrl
// Single-clock first-word-fall-through FIFO controller for the drm_32x1024
// simple dual-port RAM. Writes go straight to the RAM; reads are issued ahead
// into a 2-entry prefetch buffer so the 1-cycle RAM latency is hidden and
// 1 word/cycle streaming is sustained. Capacity is DEPTH + 2 words.
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid, s_ready, s_data   write stream
//   m_valid, m_ready, m_data   read stream (FWFT)
//   ram_wr_en/addr/data        RAM write port (combinational)
//   ram_rd_addr                RAM read address (registered read pointer)
//   ram_rd_data                RAM read data, one cycle after ram_rd_addr
//   count                      words held in RAM + in flight + buffer
//   almost_full                count >= AFULL_THRESH (registered)
//   empty                      count == 0
module drm_fifo_ctrl
    import drm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DRM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DRM_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH = DRM_AFULL_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   RAM_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] AFULL_LVL = (ADDR_WIDTH + 2)'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    // Words written to RAM but not yet read-issued.
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_WIDTH+1:0] count_q, count_d;
    logic                  afull_q;
    logic                  pend_q;

    logic     push, pop, issue;
    buf_cnt_t buf_cnt;
    buf_cnt_t buf_post_pop;
    logic [BUF_CNT_WIDTH:0] buf_committed;

    // Write path.
    assign s_ready     = (ram_cnt_q != RAM_FULL);
    assign push        = s_valid & s_ready;
    assign ram_wr_en   = push;
    assign ram_wr_addr = wptr_q;
    assign ram_wr_data = s_data;

    // Read issue: use the occupancy left after this cycle's pop so a word can
    // be issued every cycle while the consumer keeps draining.
    assign pop           = m_valid & m_ready;
    assign buf_post_pop  = buf_cnt - buf_cnt_t'(pop);
    assign buf_committed = {1'b0, buf_post_pop} + {{BUF_CNT_WIDTH{1'b0}}, pend_q};
    assign issue         = (ram_cnt_q != '0) &&
                           (buf_committed < (BUF_CNT_WIDTH + 1)'(BUF_ENTRIES));
    assign ram_rd_addr   = rptr_q;

    drm_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pend_q),
        .in_data   (ram_rd_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .occupancy (buf_cnt)
    );

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        count_d   = count_q;

        if (push) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end

        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH + 1)'(1);
            default: ;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 2)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 2)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            afull_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            afull_q   <= (count_d >= AFULL_LVL);
            // RAM output is valid one cycle after the address is sampled.
            pend_q    <= issue;
        end
    end

    assign count       = count_q;
    assign almost_full = afull_q;
    assign empty       = (count_q == '0);

endmodule

// File: tb/tb_drm_fifo_ctrl.sv
module tb_drm_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_wr_en;
    logic [AW+1:0] count;
    logic          almost_full, empty;

    drm_fifo_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (1008)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .ram_wr_data (ram_wr_data),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty)
    );

    drm_32x1024 u_ram (
        .wr_clk  (clk),
        .wr_rst  (~rst_n),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_clk  (clk),
        .rd_rst  (~rst_n),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    int            model_count = 0;
    logic          mon_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] next_data = '0;
    logic          acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, compares pops against
    // the expected queue, then records handshakes that complete at the next
    // rising edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("count", count, 64'(model_count));
            check("empty", empty, model_count == 0);
            check("almost_full", almost_full, model_count >= 1008);
            if (model_count < 1024) check("s_ready_space", s_ready, 1);
            if (model_count == 1026) check("s_ready_full", s_ready, 0);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got word 0x%0h, expected no output", m_data);
                end else begin
                    check("pop_data", m_data, exp_q.pop_front());
                end
                model_count--;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                model_count++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // One cycle: drive after the rising edge, return just after the falling
    // edge with acc telling whether the write is accepted at the next edge.
    task automatic step(input logic sv, input logic mr, output logic accepted);
        @(posedge clk);
        #1;
        s_valid = sv;
        s_data  = next_data;
        m_ready = mr;
        @(negedge clk);
        accepted = sv && s_ready;
        if (accepted) next_data++;
        #1;
    endtask

    task automatic fill(input int n);
        int got = 0;
        logic a;
        for (int i = 0; i < n + 100 && got < n; i++) begin
            step(1'b1, 1'b0, a);
            if (a) got++;
        end
        check("fill_accepted", 64'(got), 64'(n));
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 1200 && exp_q.size() != 0; i++) begin
            step(1'b0, 1'b1, a);
        end
        step(1'b0, 1'b1, a);
        check("drain_left", 64'(exp_q.size()), 0);
        check("drain_empty", empty, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        #12;
        check("rst_count", count, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_empty", empty, 1);
        check("rst_s_ready", s_ready, 1);
        check("rst_almost_full", almost_full, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single word: visible 2 cycles after the push edge.
        next_data = 32'hDEAD_BEEF;
        step(1'b1, 1'b1, acc);
        check("single_accept", acc, 1);
        step(1'b0, 1'b1, acc);
        check("lat_e0_valid", m_valid, 0);
        step(1'b0, 1'b1, acc);
        check("lat_e1_valid", m_valid, 0);
        step(1'b0, 1'b1, acc);
        check("lat_e2_valid", m_valid, 1);
        check("lat_e2_data", m_data, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, acc);
        check("single_empty", empty, 1);

        // Fill to capacity, then drain in order.
        next_data = 0;
        fill(1026);
        step(1'b0, 1'b0, acc);
        check("fill_s_ready", s_ready, 0);
        check("fill_count", count, 1026);
        check("fill_afull", almost_full, 1);
        drain();

        // Streaming with no bubbles, wrapping the RAM pointers several times.
        next_data = 32'h1000_0000;
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, 1'b1, acc);
            if (i >= 3) begin
                check("stream_m_valid", m_valid, 1);
                check("stream_s_ready", s_ready, 1);
            end
        end
        drain();

        // Full with simultaneous push and pop.
        next_data = 32'h2000_0000;
        fill(1026);
        step(1'b1, 1'b1, acc);
        check("full_hold_s_ready", s_ready, 0);
        check("full_hold_count", count, 1026);
        step(1'b1, 1'b1, acc);
        check("full_reassert", s_ready, 1);
        check("full_count_after_pop", count, 1025);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, acc);
            check("full_count_range", (count >= 1025) && (count <= 1026), 1);
        end
        drain();

        // Random back-pressure.
        next_data = 32'h3000_0000;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
        end
        drain();

        // Reset mid-stream with 500 words held.
        next_data = 32'h4000_0000;
        fill(500);
        step(1'b0, 1'b0, acc);
        check("pre_reset_count", count, 500);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_empty", empty, 1);
        exp_q.delete();
        model_count = 0;
        prev_stall  = 1'b0;
        #1;
        rst_n = 1'b1;
        next_data = 32'h5;
        step(1'b1, 1'b1, acc);
        step(1'b0, 1'b1, acc);
        step(1'b0, 1'b1, acc);
        step(1'b0, 1'b1, acc);
        check("post_rst_valid", m_valid, 1);
        check("post_rst_first", m_data, 32'h5);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
